// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM-style slave: 7-bit device address, 16-bit byte pointer,
// sequential write with commit strobe, sequential/random read.
// SCL/SDA are oversampled on clk; the bus side is open-drain (sda_oe only).
`timescale 1ns/1ps
module i2c_eeprom_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000,
  parameter int         MEM_DEPTH  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        busy,
  output logic        wr_pulse,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_byte
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_ack_on;   // first SCL fall of an ACK slot already seen
  logic        r_rw;
  logic [15:0] r_ptr;
  logic        r_sda_oe;
  logic        r_wr_pulse;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_byte;
  logic [7:0]  r_mem [MEM_DEPTH];

  logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic       w_start, w_stop, w_rise, w_fall, w_commit;
  logic [7:0] w_byte, w_rd_byte;

  // two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl;      r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda_in;   r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_sda_rise = r_sda_s2 & ~r_sda_d;
  assign w_sda_fall = ~r_sda_s2 & r_sda_d;
  // bus conditions win over bit handling in the same clk
  assign w_start    = w_sda_fall & r_scl_s2;
  assign w_stop     = w_sda_rise & r_scl_s2;
  assign w_rise     = w_scl_rise & ~w_start & ~w_stop;
  assign w_fall     = w_scl_fall & ~w_start & ~w_stop;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_rd_byte  = r_mem[r_ptr[AW-1:0]];
  assign w_commit   = (r_state == WR_DATA) && w_rise && (r_bitcnt == 3'd7);

  // protocol FSM: shifts on SCL rise, changes SDA only on SCL fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_ack_on   <= 1'b0;
      r_rw       <= 1'b0;
      r_ptr      <= 16'h0000;
      r_sda_oe   <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= 16'h0000;
      r_wr_byte  <= 8'h00;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_start) begin
        r_state  <= DEV_ADDR;
        r_bitcnt <= 3'd0;
        r_sda_oe <= 1'b0;
        r_ack_on <= 1'b0;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        r_ack_on <= 1'b0;
      end else begin
        case (r_state)
          DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA: begin
            if (w_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              r_ack_on <= 1'b0;
              if (r_bitcnt == 3'd7) begin
                case (r_state)
                  DEV_ADDR: begin
                    r_rw    <= r_sda_s2;
                    r_state <= (r_shift[6:0] == SLAVE_ADDR) ? ACK_DEV : IGNORE;
                  end
                  ADDR_HI: begin
                    r_ptr[15:8] <= w_byte;
                    r_state     <= ACK_HI;
                  end
                  ADDR_LO: begin
                    r_ptr[7:0] <= w_byte;
                    r_state    <= ACK_LO;
                  end
                  default: begin
                    r_wr_pulse <= 1'b1;
                    r_wr_addr  <= r_ptr;
                    r_wr_byte  <= w_byte;
                    r_state    <= ACK_WR;
                  end
                endcase
              end
            end
          end
          ACK_DEV, ACK_HI, ACK_LO, ACK_WR: begin
            if (w_fall) begin
              if (!r_ack_on) begin
                // fall ending the 8th bit: pull SDA for the ACK slot
                r_sda_oe <= 1'b1;
                r_ack_on <= 1'b1;
              end else begin
                // fall ending the ACK slot
                r_ack_on <= 1'b0;
                r_bitcnt <= 3'd0;
                r_sda_oe <= 1'b0;
                case (r_state)
                  ACK_DEV: begin
                    if (r_rw) begin
                      r_sda_oe <= ~w_rd_byte[7];
                      r_shift  <= {w_rd_byte[6:0], 1'b0};
                      r_state  <= RD_DATA;
                    end else begin
                      r_state  <= ADDR_HI;
                    end
                  end
                  ACK_HI:  r_state <= ADDR_LO;
                  ACK_LO:  r_state <= WR_DATA;
                  default: begin
                    r_ptr   <= r_ptr + 16'd1;
                    r_state <= WR_DATA;
                  end
                endcase
              end
            end
          end
          RD_DATA: begin
            if (w_fall) begin
              if (r_bitcnt == 3'd7) begin
                r_sda_oe <= 1'b0;
                r_ptr    <= r_ptr + 16'd1;
                r_ack_on <= 1'b0;
                r_state  <= RD_ACK;
              end else begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (w_rise) begin
              if (r_sda_s2) r_state  <= IGNORE;
              else          r_ack_on <= 1'b1;
            end else if (w_fall && r_ack_on) begin
              r_ack_on <= 1'b0;
              r_bitcnt <= 3'd0;
              r_sda_oe <= ~w_rd_byte[7];
              r_shift  <= {w_rd_byte[6:0], 1'b0};
              r_state  <= RD_DATA;
            end
          end
          IDLE, IGNORE: r_sda_oe <= 1'b0;
          default: begin
            r_state  <= IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  // byte storage; deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_ptr[AW-1:0]] <= w_byte;
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = (r_state != IDLE) && (r_state != IGNORE);
  assign wr_pulse = r_wr_pulse;
  assign wr_addr  = r_wr_addr;
  assign wr_byte  = r_wr_byte;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: a bit-banged I2C master on an
// open-drain bus, a table of write/readback transactions, and hand-written
// sequences for reset-during-ACK and STOP-inside-a-byte.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
  localparam int Q = 60;  // quarter SCL bit time, 6 clk

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_oe, busy, wr_pulse;
  logic [15:0] wr_addr;
  logic [7:0]  wr_byte;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .busy(busy), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .wr_byte(wr_byte)
  );

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];

  always @(negedge clk) if (wr_pulse) wq.push_back('{wr_addr, wr_byte});

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic start_c();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic stop_c();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  task automatic bit_cycle(input logic b, output logic smp);
    m_sda = b; #Q; m_scl = 1'b1; #Q; smp = sda_bus; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [15:0] ptr;
    logic [7:0]  d0, d1;
    logic        exp_ack;
    logic [15:0] exp_a0, exp_a1, exp_ptr;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic       ack;
    logic [7:0] rb;
    logic [7:0] dbyte;

    vt[0] = '{8'hA0, 16'h0010, 8'h5A, 8'hA5, 1'b1, 16'h0010, 16'h0011, 16'h0012};
    vt[1] = '{8'hA0, 16'h00FF, 8'h11, 8'h22, 1'b1, 16'h00FF, 16'h0100, 16'h0101};
    vt[2] = '{8'hA2, 16'h0030, 8'h77, 8'h88, 1'b0, 16'h0000, 16'h0000, 16'h0101};
    vt[3] = '{8'hA0, 16'hFFFF, 8'hC3, 8'h3C, 1'b1, 16'hFFFF, 16'h0000, 16'h0001};

    // reset values
    #52;
    chk("rst_sda_oe",  sda_oe,    0);
    chk("rst_busy",    busy,      0);
    chk("rst_wr_pulse",wr_pulse,  0);
    chk("rst_wr_addr", wr_addr,   0);
    chk("rst_wr_byte", wr_byte,   0);
    chk("rst_ptr",     dut.r_ptr, 0);
    rst_n = 1'b1;
    #Q;

    // table: two-byte write, then random read of the same two bytes
    for (int i = 0; i < 4; i++) begin
      wq.delete();
      start_c();
      send_byte(vt[i].dev, ack);
      chk($sformatf("v%0d_dev_ack", i), ack, vt[i].exp_ack);
      if (vt[i].exp_ack) begin
        chk($sformatf("v%0d_busy", i), busy, 1);
        send_byte(vt[i].ptr[15:8], ack); chk($sformatf("v%0d_ack_hi", i), ack, 1);
        send_byte(vt[i].ptr[7:0],  ack); chk($sformatf("v%0d_ack_lo", i), ack, 1);
        send_byte(vt[i].d0, ack);        chk($sformatf("v%0d_ack_d0", i), ack, 1);
        send_byte(vt[i].d1, ack);        chk($sformatf("v%0d_ack_d1", i), ack, 1);
        stop_c();
        chk($sformatf("v%0d_npulse", i), wq.size(), 2);
        if (wq.size() == 2) begin
          chk($sformatf("v%0d_wa0", i), wq[0].a, vt[i].exp_a0);
          chk($sformatf("v%0d_wd0", i), wq[0].d, vt[i].d0);
          chk($sformatf("v%0d_wa1", i), wq[1].a, vt[i].exp_a1);
          chk($sformatf("v%0d_wd1", i), wq[1].d, vt[i].d1);
        end
        chk($sformatf("v%0d_ptr_wr", i), dut.r_ptr, vt[i].exp_ptr);
        chk($sformatf("v%0d_idle_busy", i), busy, 0);
        // random read: set pointer, repeated START, read with ACK then NACK
        start_c();
        send_byte(vt[i].dev, ack);
        send_byte(vt[i].ptr[15:8], ack);
        send_byte(vt[i].ptr[7:0], ack);
        start_c();
        send_byte(vt[i].dev | 8'h01, ack);
        chk($sformatf("v%0d_rd_ack", i), ack, 1);
        recv_byte(1'b0, rb); chk($sformatf("v%0d_rd0", i), rb, vt[i].d0);
        recv_byte(1'b1, rb); chk($sformatf("v%0d_rd1", i), rb, vt[i].d1);
        chk($sformatf("v%0d_ign_busy", i), busy, 0);
        stop_c();
        chk($sformatf("v%0d_ptr_rd", i), dut.r_ptr, vt[i].exp_ptr);
      end else begin
        chk($sformatf("v%0d_nack_busy", i), busy, 0);
        stop_c();
        chk($sformatf("v%0d_npulse", i), wq.size(), 0);
        chk($sformatf("v%0d_ptr", i), dut.r_ptr, vt[i].exp_ptr);
      end
    end

    // reset during the ACK slot of a data byte at pointer 0000
    wq.delete();
    dbyte = 8'h9C;
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    send_byte(8'h00, ack);
    for (int i = 7; i >= 0; i--) bit_cycle(dbyte[i], ack);
    m_sda = 1'b1;
    #Q;
    chk("rstack_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rstack_oe_after", sda_oe, 0);
    chk("rstack_busy", busy, 0);
    #20;
    rst_n = 1'b1;
    m_scl = 1'b1;
    #Q;
    start_c();
    send_byte(8'hA1, ack);
    chk("rstack_rd_ack", ack, 1);
    recv_byte(1'b1, rb);
    chk("rstack_rd0", rb, 8'h9C);
    stop_c();
    chk("rstack_ptr", dut.r_ptr, 16'h0001);
    chk("rstack_npulse", wq.size(), 1);
    if (wq.size() == 1) chk("rstack_wa", wq[0].a, 16'h0000);

    // STOP after four data bits: no commit, pointer kept
    wq.delete();
    start_c();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    send_byte(8'h40, ack);
    chk("stop4_ack_lo", ack, 1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, ack);
    stop_c();
    #Q;
    chk("stop4_npulse", wq.size(), 0);
    chk("stop4_busy", busy, 0);
    chk("stop4_ptr", dut.r_ptr, 16'h0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
